// File: rtl/sd_ssp_engine_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sd_pkg -- shared state, status and prescaler definitions for sd_ssp   |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package sd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVR  = 2;

  localparam logic [7:0] DEFAULT_PRES = 8'd4;

  // A prescaler of zero would stall the half-period counter, so it runs as 1.
  function automatic logic [7:0] half_period(input logic [7:0] pres);
    return (pres == 8'd0) ? 8'd1 : pres;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_ssp_engine_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sd_ssp_engine_if -- register-block side of the SD shift engine        |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
interface sd_ssp_engine_if;

  logic       sspshif_i;
  logic [7:0] ssppres_i8;
  logic [7:0] ssptdat_i8;
  logic [7:0] ssprdat_o8;
  logic [7:0] sspstat_o8;

  modport master (
    output sspshif_i,
    output ssppres_i8,
    output ssptdat_i8,
    input  ssprdat_o8,
    input  sspstat_o8
  );

  modport slave (
    input  sspshif_i,
    input  ssppres_i8,
    input  ssptdat_i8,
    output ssprdat_o8,
    output sspstat_o8
  );

endinterface
`default_nettype wire

// File: rtl/sd_ssp_engine_sync.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sd_sync -- N-flop synchroniser with asynchronous active-high reset    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module sd_sync #(
  parameter int N = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule
`default_nettype wire

// File: rtl/sd_ssp_engine.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sd_ssp_engine -- SPI mode-0 full-duplex byte shift engine for SD cards |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module sd_ssp_engine
  import sd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit IDLE_MOSI   = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  sd_ssp_engine_if.slave bus,
  output logic           sclk_o,
  output logic           mosi_o,
  input  logic           miso_i
);

  logic       shif_s;
  logic       miso_s;
  logic       start;
  logic       shif_prev_q;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] half_q, half_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] rdat_q, rdat_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ovr_q, ovr_d;

  sd_sync #(.N(SYNC_STAGES)) u_shif_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (bus.sspshif_i),
    .q_o   (shif_s)
  );

  sd_sync #(.N(2)) u_miso_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (miso_i),
    .q_o   (miso_s)
  );

  assign start = shif_s & ~shif_prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      shif_prev_q <= 1'b0;
      cnt_q       <= 8'd0;
      half_q      <= 8'd0;
      shreg_q     <= 8'd0;
      rdat_q      <= 8'd0;
      bitcnt_q    <= 3'd0;
      sclk_q      <= 1'b0;
      mosi_q      <= IDLE_MOSI;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shif_prev_q <= shif_s;
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      shreg_q     <= shreg_d;
      rdat_q      <= rdat_d;
      bitcnt_q    <= bitcnt_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    half_d   = half_q;
    shreg_d  = shreg_q;
    rdat_d   = rdat_q;
    bitcnt_d = bitcnt_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    busy_d   = busy_q;
    done_d   = done_q;
    ovr_d    = ovr_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          half_d   = half_period(bus.ssppres_i8);
          cnt_d    = half_period(bus.ssppres_i8);
          shreg_d  = bus.ssptdat_i8;
          bitcnt_d = 3'd0;
          mosi_d   = bus.ssptdat_i8[7];
          busy_d   = 1'b1;
          done_d   = 1'b0;
          ovr_d    = 1'b0;
          state_d  = LOW;
        end
      end
      LOW: begin
        if (cnt_q == 8'd1) begin
          cnt_d   = half_q;
          sclk_d  = 1'b1;
          shreg_d = {shreg_q[6:0], miso_s};
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HIGH: begin
        if (cnt_q == 8'd1) begin
          cnt_d  = half_q;
          sclk_d = 1'b0;
          // Data and status are committed together so they appear in DONE as one coherent update.
          if (bitcnt_q == 3'd7) begin
            rdat_d  = shreg_q;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            mosi_d  = IDLE_MOSI;
            state_d = DONE;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
            mosi_d   = shreg_q[7];
            state_d  = LOW;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (start && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end
  end

  always_comb begin
    bus.sspstat_o8            = 8'd0;
    bus.sspstat_o8[STAT_BUSY] = busy_q;
    bus.sspstat_o8[STAT_DONE] = done_q;
    bus.sspstat_o8[STAT_OVR]  = ovr_q;
  end

  assign bus.ssprdat_o8 = rdat_q;
  assign sclk_o         = sclk_q;
  assign mosi_o         = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_ssp_engine.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_sd_ssp_engine -- scoreboard bench for the SD SPI shift engine       |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_sd_ssp_engine;
  import sd_pkg::*;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk, mosi, miso;

  sd_ssp_engine_if bus();

  sd_ssp_engine #(.SYNC_STAGES(SYNC), .IDLE_MOSI(1'b1)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (bus),
    .sclk_o (sclk),
    .mosi_o (mosi),
    .miso_i (miso)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tdat;
    logic [7:0] rdat;
    logic [7:0] stat;
    int         h;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Card model: presents the next MSB-first bit right after each sclk rise.
  // At H=1 the two-flop miso synchroniser spans a whole sclk period, so the
  // card launches one bit ahead (card_lead=1); this needs byte[7]==byte[6].
  int         rise_total = 0;
  int         card_base  = 0;
  int         card_lead  = 0;
  int         card_k;
  logic       loopback   = 1'b0;
  logic [7:0] card_byte  = 8'hFF;

  always @(posedge sclk) rise_total <= rise_total + 1;

  always_comb begin
    card_k = rise_total - card_base + card_lead;
    if (loopback) miso = mosi;
    else if (card_k >= 0 && card_k < 8) miso = card_byte[7 - card_k];
    else miso = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic [7:0] tdat, input logic [7:0] pres, input bit loop,
                            input logic [7:0] card, input int lead, input logic [7:0] exp_stat);
    int h;
    int seen;
    h = (pres == 8'd0) ? 1 : int'(pres);
    bus.ssptdat_i8 = tdat;
    bus.ssppres_i8 = pres;
    loopback  = loop;
    card_byte = card;
    card_lead = lead;
    card_base = rise_total;
    sb.push_back('{tdat, (loop ? tdat : card), exp_stat, h});
    seen = 0;
    bus.sspshif_i = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (seen == 0 && bus.sspstat_o8[STAT_BUSY]) seen = c;
    end
    bus.sspshif_i = 1'b0;
    check("strobe_to_busy", seen, SYNC + 1);
  endtask

  task automatic pulse_strobe();
    bus.sspshif_i = 1'b1;
    repeat (5) tick();
    bus.sspshif_i = 1'b0;
  endtask

  task automatic wait_idle(input int h);
    int n;
    n = 0;
    while (bus.sspstat_o8[STAT_BUSY] && n < 16 * h + 40) begin
      tick();
      n++;
    end
    if (bus.sspstat_o8[STAT_BUSY]) check("xfer_timeout", 1, 0);
    repeat (3) tick();
  endtask

  // Monitor: pops an expectation at busy rise, measures the sclk waveform and
  // the transmitted bits, and compares the results when busy falls.
  initial begin : monitor
    exp_t       cur;
    logic       pb, ps, b, s;
    int         blen, run, rises, herr;
    logic [7:0] mb;
    bit         active;
    pb = 1'b0; ps = 1'b0; active = 1'b0;
    blen = 0; run = 0; rises = 0; herr = 0; mb = 8'd0;
    cur = '{8'd0, 8'd0, 8'd0, 1};
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        pb = 1'b0; ps = 1'b0; active = 1'b0;
      end else begin
        b = bus.sspstat_o8[STAT_BUSY];
        s = sclk;
        if (b && !pb) begin
          if (sb.size() == 0) begin
            check("unexpected_xfer", 1, 0);
            active = 1'b0;
          end else begin
            cur = sb.pop_front();
            active = 1'b1;
          end
          blen = 0; run = 0; rises = 0; herr = 0; mb = 8'd0;
        end
        if (b) begin
          blen++;
          if (s != ps) begin
            if (run != cur.h) herr++;
            run = 1;
            if (s) begin
              rises++;
              mb = {mb[6:0], mosi};
            end
          end else begin
            run++;
          end
        end else if (pb && active) begin
          if (ps && run != cur.h) herr++;
          check("rdat", bus.ssprdat_o8, cur.rdat);
          check("stat", bus.sspstat_o8, cur.stat);
          check("sclk_rises", rises, 8);
          check("mosi_byte", mb, cur.tdat);
          check("busy_len", blen, 16 * cur.h);
          check("half_period_errs", herr, 0);
          check("idle_mosi", mosi, 1);
          active = 1'b0;
        end
        pb = b;
        ps = s;
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int         base, n, bad, h;
    logic [7:0] pres, tdat, card;
    bit         loop, ovr;

    bus.sspshif_i  = 1'b0;
    bus.ssppres_i8 = DEFAULT_PRES;
    bus.ssptdat_i8 = 8'h00;
    repeat (3) tick();
    check("reset_rdat", bus.ssprdat_o8, 8'h00);
    check("reset_stat", bus.sspstat_o8, 8'h00);
    check("reset_sclk", sclk, 0);
    check("reset_mosi", mosi, 1);
    rst = 1'b0;
    repeat (2) tick();

    start_xfer(8'hA5, 8'd4, 1'b1, 8'h00, 0, 8'h02);
    wait_idle(4);
    start_xfer(8'hFF, 8'd1, 1'b0, 8'h3C, 1, 8'h02);
    wait_idle(1);
    start_xfer(8'h96, 8'd0, 1'b0, 8'h3C, 1, 8'h02);
    wait_idle(1);
    start_xfer(8'h69, 8'd255, 1'b1, 8'h00, 0, 8'h02);
    wait_idle(255);

    // Overrun: second strobe mid-transfer with a different data byte.
    start_xfer(8'h5A, 8'd4, 1'b1, 8'h00, 0, 8'h06);
    repeat (10) tick();
    bus.ssptdat_i8 = 8'h00;
    pulse_strobe();
    wait_idle(4);
    start_xfer(8'h11, 8'd4, 1'b1, 8'h00, 0, 8'h02);
    check("ovr_cleared_stat", bus.sspstat_o8, 8'h01);
    wait_idle(4);

    // Prescaler change mid-transfer only affects the following transfer.
    start_xfer(8'hE7, 8'd4, 1'b1, 8'h00, 0, 8'h02);
    repeat (5) tick();
    bus.ssppres_i8 = 8'd2;
    wait_idle(4);
    start_xfer(8'h18, 8'd2, 1'b0, 8'hB2, 0, 8'h02);
    wait_idle(2);

    // Asynchronous reset after the third sclk rise.
    start_xfer(8'hC6, 8'd4, 1'b1, 8'h00, 0, 8'h02);
    base = card_base;
    n = 0;
    while ((rise_total - base) < 3 && n < 200) begin
      tick();
      n++;
    end
    check("third_rise_seen", ((rise_total - base) >= 3), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_sclk", sclk, 0);
    check("async_rst_mosi", mosi, 1);
    check("async_rst_rdat", bus.ssprdat_o8, 8'h00);
    check("async_rst_stat", bus.sspstat_o8, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.sspstat_o8 != 8'h00 || sclk) bad++;
    end
    check("no_spurious_after_rst", bad, 0);

    for (int i = 0; i < 16; i++) begin
      pres = 8'($urandom_range(0, 6));
      h    = (pres == 8'd0) ? 1 : int'(pres);
      tdat = 8'($urandom);
      card = 8'($urandom);
      loop = (h >= 3) && ($urandom_range(0, 1) == 1);
      ovr  = (h >= 2) && ($urandom_range(0, 3) == 0);
      if (h == 1) card[6] = card[7];
      start_xfer(tdat, pres, loop, card, (h == 1) ? 1 : 0, ovr ? 8'h06 : 8'h02);
      if (ovr) begin
        repeat (2) tick();
        bus.ssptdat_i8 = 8'($urandom);
        bus.ssppres_i8 = 8'($urandom_range(0, 6));
        pulse_strobe();
      end
      wait_idle(h);
    end

    repeat (5) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
